led_frame_loader: RTL
=====================

Name: led_frame_loader

Overview:
- Upstream stage of the LED panel column/row driver. Receives image data from an external host over a 3-wire serial link (SPI mode 0, MSB first) and holds it in a double-buffered 16-column x 8-bit frame store.
- The panel driver reads the front buffer combinationally and signals each frame boundary. The loader swaps buffers only at a boundary, so the panel never shows a partial frame.

Parameters:
- NCOLS, 16, number of frame columns; must be a power of two; column index width is log2(NCOLS).
- SYNC_STAGES, 2, number of flip-flop stages in the synchroniser for sck, scs_n and sdi.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; the block resets when reset==0 at a clk rising edge.
- sck  in  1  serial clock; asynchronous to clk; frequency at most clk/4.
- scs_n  in  1  serial chip select, active-low; asynchronous.
- sdi  in  1  serial data in; asynchronous.
- frame_sync  in  1  one-cycle pulse from the panel driver when the row counter wraps from 3 to 0.
- rd_col  in  4  front-buffer column select from the panel driver.
- rd_data  out  8  front-buffer column contents; combinational from rd_col.
- rgb  out  3  active colour {r,g,b}; registered.
- busy  out  1  high while a COPY is in progress or a swap is pending.

Behaviour:
- Synchroniser: sck, scs_n and sdi each pass through SYNC_STAGES flops. An sck rising edge is detected from the last two sck stages.
- Receiver: a bit is sampled on each detected sck rise while synced scs_n==0. After 8 bits, a byte_valid strobe lasts one cycle.
- Synced scs_n==1 clears the bit counter and the byte index. A partial byte is discarded.
- Byte 0 of a transaction is the header:
  - bits[7:4] = start column, loaded into wr_ptr.
  - bits[2:0] = back colour, loaded into rgb_back.
  - bit 3 is ignored.
- Each following byte writes back_buf[wr_ptr], then wr_ptr increments. wr_ptr wraps from 15 to 0.
- More than 16 data bytes overwrite earlier columns in wrap order.
- Transaction end: on a synced scs_n rising edge, if at least one data byte was written, swap_pending is set. A header-only transaction leaves swap_pending unchanged.
- Buffers: two 16x8 arrays. front_sel selects which array is front. rd_data = front[rd_col], with zero cycles of latency.
- Control FSM has states IDLE and COPY.
  - IDLE: if frame_sync==1 and swap_pending==1:
    - front_sel toggles and rgb is loaded from rgb_back, both on the same edge.
    - swap_pending clears and the FSM enters COPY with copy_idx=0.
  - COPY: each cycle, new back[copy_idx] = new front[copy_idx] and copy_idx increments. After copy_idx==15 the FSM returns to IDLE, so COPY lasts 16 cycles. This keeps partial updates incremental.
- Writes during COPY: a data byte completed during COPY goes into a one-byte holding register together with its target column. It is written on the first IDLE cycle, after the copy, so it is never overwritten. The sck ≤ clk/4 limit guarantees at most one held byte.
- Simultaneous events:
  - frame_sync during COPY is ignored; swap_pending is retained and serviced at the next frame_sync in IDLE.
  - frame_sync on the same cycle swap_pending is set does not swap; the swap occurs at the next frame_sync.
  - A byte write and the swap on the same edge: the write targets the new back buffer.
- busy = (state==COPY) | swap_pending.
- Reset: the following values apply, and reset mid-transaction or mid-COPY abandons all progress with no partial write.
  - Both buffers are cleared to 0, or to the default image (see below).
  - front_sel=0, rgb=3'b100, rgb_back=3'b100, swap_pending=0, state=IDLE.
  - Bit counter, byte index, wr_ptr and holding register are cleared.

Optional Feature:
- Macro FRAME_LOADER_DEFAULT_IMAGE_EN.
- When defined, reset loads both buffers with the "TT03" splash, listed as columns 15..0:
  - 04 7C 04 00 04 7C 04 00
  - 38 44 38 00 54 54 28 00 (hex)
  - The colour reset value stays 3'b100.
- When undefined, both buffers reset to all zeros.

Test Plan:
- Reset, then drive rd_col 0..15 -> rd_data==8'h00 for every column (with the macro: the splash bytes), rgb==3'b100, busy==0.
- Send header 8'h21 then data 8'hAA, 8'h55; raise scs_n; pulse frame_sync -> swap occurs on that edge and busy==1 for 16 cycles after it, then busy==0. Final state: rd_data[2]==8'hAA, rd_data[3]==8'h55, rgb==3'b001, other columns unchanged.
- Send header 8'hF0 then data 8'h11, 8'h22; swap -> col15==8'h11 and col0==8'h22 (wrap-around).
- Send a 3-byte transaction; pulse frame_sync 1 cycle after scs_n rises (on the set cycle) -> no swap; next frame_sync swaps.
- Complete a data byte during COPY (col5 = 8'h3C) -> after a second transaction and swap, rd_data[5]==8'h3C and the copied columns are intact. frame_sync during COPY is ignored.
- Pull reset low mid-byte and mid-COPY -> all outputs return to reset values; next transaction works normally.

Source files
------------

// File: rtl/led_frame_loader.sv
// Serial (SPI mode 0) frame loader with a double-buffered column store for the LED panel driver.
// Define FRAME_LOADER_DEFAULT_IMAGE_EN to reset both buffers to the "TT03" splash instead of zeros.
module led_frame_loader #(
  parameter int NCOLS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     scs_n,
  input  logic                     sdi,
  input  logic                     frame_sync,
  input  logic [$clog2(NCOLS)-1:0] rd_col,
  output logic [7:0]               rd_data,
  output logic [2:0]               rgb,
  output logic                     busy
);
  localparam int CW = $clog2(NCOLS);

  typedef logic [NCOLS-1:0][7:0] img_t;
  typedef enum logic {IDLE, COPY} state_t;

`ifdef FRAME_LOADER_DEFAULT_IMAGE_EN
  localparam logic [127:0] SPLASH = 128'h047C_0400_047C_0400_3844_3800_5454_2800;
`endif

  function automatic img_t init_image();
    img_t img = '0;
`ifdef FRAME_LOADER_DEFAULT_IMAGE_EN
    for (int i = 0; i < NCOLS; i++) img[i] = SPLASH[(i % 16)*8 +: 8];
`endif
    return img;
  endfunction

  localparam img_t INIT_IMG = init_image();

  // synchronisers; chip select idles high so reset never fakes an edge
  logic [SYNC_STAGES-1:0] sck_q, cs_q, sdi_q;
  logic sck_rise, cs_s, sdi_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_q <= '0;
      cs_q  <= '1;
      sdi_q <= '0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q  <= {cs_q[SYNC_STAGES-2:0], scs_n};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];

  // byte receiver
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_vld;
  logic [7:0] rx_byte;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      rx_byte  <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {shreg[5:0], sdi_s};
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          rx_byte  <= {shreg, sdi_s};
        end
      end
    end
  end

  // frame store and control
  img_t          buf0, buf1;
  state_t        state;
  logic [CW-1:0] copy_idx, wr_ptr, hold_col;
  logic [7:0]    hold_data;
  logic          hold_vld, front_sel, swap_pending, hdr_seen, wrote, cs_d;
  logic [2:0]    rgb_back;
  logic          cs_rise, data_vld, swap_now;

  assign cs_rise  = cs_s & ~cs_d;
  assign data_vld = byte_vld & hdr_seen;
  // a pending held byte is flushed before the next swap is taken
  assign swap_now = (state == IDLE) & frame_sync & swap_pending & ~hold_vld;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf0         <= INIT_IMG;
      buf1         <= INIT_IMG;
      state        <= IDLE;
      copy_idx     <= '0;
      wr_ptr       <= '0;
      hold_col     <= '0;
      hold_data    <= '0;
      hold_vld     <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      hdr_seen     <= 1'b0;
      wrote        <= 1'b0;
      cs_d         <= 1'b1;
      rgb          <= 3'b100;
      rgb_back     <= 3'b100;
    end else begin
      cs_d <= cs_s;
      case (state)
        IDLE: begin
          if (hold_vld) begin
            if (front_sel) buf0[hold_col] <= hold_data;
            else           buf1[hold_col] <= hold_data;
            hold_vld <= 1'b0;
          end
          if (swap_now) begin
            front_sel    <= ~front_sel;
            rgb          <= rgb_back;
            swap_pending <= 1'b0;
            copy_idx     <= '0;
            state        <= COPY;
          end
        end
        COPY: begin
          // front_sel already names the new front buffer here
          if (front_sel) buf0[copy_idx] <= buf1[copy_idx];
          else           buf1[copy_idx] <= buf0[copy_idx];
          copy_idx <= copy_idx + 1'b1;
          if (copy_idx == CW'(NCOLS-1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (byte_vld && !hdr_seen) begin
        wr_ptr   <= rx_byte[7 -: CW];
        rgb_back <= rx_byte[2:0];
        hdr_seen <= 1'b1;
      end

      if (data_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
        wrote  <= 1'b1;
        // park bytes that would otherwise be clobbered by the copy pass
        if (state == COPY || swap_now) begin
          hold_vld  <= 1'b1;
          hold_col  <= wr_ptr;
          hold_data <= rx_byte;
        end else if (front_sel) begin
          buf0[wr_ptr] <= rx_byte;
        end else begin
          buf1[wr_ptr] <= rx_byte;
        end
      end

      if (cs_s) hdr_seen <= 1'b0;

      if (cs_rise) begin
        wrote <= 1'b0;
        if (wrote || data_vld) swap_pending <= 1'b1;
      end
    end
  end

  assign rd_data = front_sel ? buf1[rd_col] : buf0[rd_col];
  assign busy    = (state == COPY) | swap_pending;

endmodule
